// File: rtl/core_pkg.sv
// Channel codes and helpers shared by the issue-side demultiplexer.
package core_pkg;

    localparam int NUM_CH = 4;

    typedef enum logic [1:0] {
        CH_A = 2'b00,
        CH_B = 2'b01,
        CH_C = 2'b10,
        CH_D = 2'b11
    } ch_e;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [1:0] code);
        logic [NUM_CH-1:0] vec;
        vec       = '0;
        vec[code] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/demux_1to4_param_if.sv
// Upstream stream plus the four downstream channels of the demultiplexer.
interface demux_1to4_param_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       control;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] input_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] output_A;
    logic [WIDTH-1:0] output_B;
    logic [WIDTH-1:0] output_C;
    logic [WIDTH-1:0] output_D;

    modport master (
        output control, in_valid, input_data, out_ready,
        input  in_ready, out_valid, output_A, output_B, output_C, output_D
    );

    modport slave (
        input  control, in_valid, input_data, out_ready,
        output in_ready, out_valid, output_A, output_B, output_C, output_D
    );
endinterface

// File: rtl/demux_1to4_param_fifo2.sv
// Two-entry channel buffer; an empty buffer keeps presenting the last popped word.
module fifo2_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head_data
);

    logic [1:0]       count_q, count_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic [WIDTH-1:0] last_q, last_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == 2'd2);
    assign valid   = (count_q != 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && valid;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        mem_d   = mem_q;
        last_d  = last_q;
        if (do_push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ~tail_q;
        end
        if (do_pop) begin
            head_d = ~head_q;
            last_d = mem_q[head_q];
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= '0;
        end else begin
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            last_q   <= last_d;
        end
    end

    // Slot at head is the live word; once drained, show what was last handed out.
    assign head_data = valid ? mem_q[head_q] : last_q;

endmodule

// File: rtl/demux_1to4_param.sv
// Steers one valid/ready stream to four independently buffered channels.
module demux_1to4_param
    import core_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    demux_1to4_param_if.slave bus
);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] push_vec;
    logic [WIDTH-1:0]  head [NUM_CH];
    logic              in_ready;

    // Depends only on control and registered counts, never on out_ready.
    assign in_ready     = !full[bus.control];
    assign bus.in_ready = in_ready;
    assign push_vec     = (bus.in_valid && in_ready) ? ch_onehot(bus.control) : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        fifo2_param #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push_vec[i]),
            .push_data (bus.input_data),
            .full      (full[i]),
            .pop       (bus.out_ready[i]),
            .valid     (valid[i]),
            .head_data (head[i])
        );
    end

    assign bus.out_valid = valid;
    assign bus.output_A  = head[CH_A];
    assign bus.output_B  = head[CH_B];
    assign bus.output_C  = head[CH_C];
    assign bus.output_D  = head[CH_D];

endmodule

// File: tb/tb_demux_1to4_param.sv
// Directed vector table plus streaming and stall sequences for demux_1to4_param.
module tb_demux_1to4_param;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    demux_1to4_param_if #(.WIDTH(32)) bus ();

    demux_1to4_param #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [1:0]  ctl;
        logic [31:0] din;
        logic [3:0]  ordy;
        logic        chk;
        logic        e_rdy;
        logic [3:0]  e_ov;
        logic [31:0] ea, eb, ec, ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic v, logic [1:0] c, logic [31:0] d, logic [3:0] o,
                                logic k, logic er, logic [3:0] eov,
                                logic [31:0] a, logic [31:0] b, logic [31:0] cc, logic [31:0] dd);
        vec_t t;
        t.rst = r; t.vld = v; t.ctl = c; t.din = d; t.ordy = o;
        t.chk = k; t.e_rdy = er; t.e_ov = eov;
        t.ea = a; t.eb = b; t.ec = cc; t.ed = dd;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        int          accepted;

        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.control = 2'd0;
        bus.input_data = 32'hDEAD_0000;
        bus.out_ready = 4'h0;

        // reset held two cycles with in_valid high
        vecs.push_back(mk(1,1,0,32'hDEADDEAD,4'h0, 0,1,4'h0, 0,0,0,0));
        vecs.push_back(mk(1,1,3,32'hBEEFBEEF,4'h0, 1,1,4'h0, 0,0,0,0));
        vecs.push_back(mk(0,0,0,32'h0,4'hF,        1,1,4'h0, 0,0,0,0));
        // routing
        vecs.push_back(mk(0,1,0,32'h11111111,4'hF, 1,1,4'h0, 0,0,0,0));
        vecs.push_back(mk(0,1,1,32'h22222222,4'hF, 1,1,4'h1, 32'h11111111,0,0,0));
        vecs.push_back(mk(0,1,2,32'h33333333,4'hF, 1,1,4'h2, 32'h11111111,32'h22222222,0,0));
        vecs.push_back(mk(0,1,3,32'h44444444,4'hF, 1,1,4'h4, 32'h11111111,32'h22222222,32'h33333333,0));
        vecs.push_back(mk(0,0,3,32'h0,4'hF,        1,1,4'h8, 32'h11111111,32'h22222222,32'h33333333,32'h44444444));
        vecs.push_back(mk(0,0,3,32'h0,4'hF,        1,1,4'h0, 32'h11111111,32'h22222222,32'h33333333,32'h44444444));
        // backpressure on C, then isolation on A
        vecs.push_back(mk(0,1,2,32'hA0,4'hB,       1,1,4'h0, 32'h11111111,32'h22222222,32'h33333333,32'h44444444));
        vecs.push_back(mk(0,1,2,32'hA1,4'hB,       1,1,4'h4, 32'h11111111,32'h22222222,32'hA0,32'h44444444));
        vecs.push_back(mk(0,1,2,32'hA2,4'hB,       1,0,4'h4, 32'h11111111,32'h22222222,32'hA0,32'h44444444));
        vecs.push_back(mk(0,1,0,32'h55,4'hB,       1,1,4'h4, 32'h11111111,32'h22222222,32'hA0,32'h44444444));
        vecs.push_back(mk(0,0,0,32'h0,4'hB,        1,1,4'h5, 32'h55,32'h22222222,32'hA0,32'h44444444));
        vecs.push_back(mk(0,1,2,32'hA2,4'hF,       1,0,4'h4, 32'h55,32'h22222222,32'hA0,32'h44444444));
        vecs.push_back(mk(0,0,2,32'h0,4'hF,        1,1,4'h4, 32'h55,32'h22222222,32'hA1,32'h44444444));
        vecs.push_back(mk(0,0,2,32'h0,4'hF,        1,1,4'h0, 32'h55,32'h22222222,32'hA1,32'h44444444));
        // simultaneous push/pop on B
        vecs.push_back(mk(0,1,1,32'hB0,4'h0,       1,1,4'h0, 32'h55,32'h22222222,32'hA1,32'h44444444));
        vecs.push_back(mk(0,1,1,32'hB1,4'h2,       1,1,4'h2, 32'h55,32'hB0,32'hA1,32'h44444444));
        vecs.push_back(mk(0,0,1,32'h0,4'h0,        1,1,4'h2, 32'h55,32'hB1,32'hA1,32'h44444444));
        vecs.push_back(mk(0,0,1,32'h0,4'h2,        1,1,4'h2, 32'h55,32'hB1,32'hA1,32'h44444444));
        vecs.push_back(mk(0,0,1,32'h0,4'h0,        1,1,4'h0, 32'h55,32'hB1,32'hA1,32'h44444444));
        // fill A and D, then reset mid-operation
        vecs.push_back(mk(0,1,0,32'hAAAA0001,4'h0, 1,1,4'h0, 32'h55,32'hB1,32'hA1,32'h44444444));
        vecs.push_back(mk(0,1,0,32'hAAAA0002,4'h0, 1,1,4'h1, 32'hAAAA0001,32'hB1,32'hA1,32'h44444444));
        vecs.push_back(mk(0,1,3,32'hDDDD0001,4'h0, 1,1,4'h1, 32'hAAAA0001,32'hB1,32'hA1,32'h44444444));
        vecs.push_back(mk(0,1,3,32'hDDDD0002,4'h0, 1,1,4'h9, 32'hAAAA0001,32'hB1,32'hA1,32'hDDDD0001));
        vecs.push_back(mk(1,1,3,32'hDDDD0003,4'h0, 1,0,4'h9, 32'hAAAA0001,32'hB1,32'hA1,32'hDDDD0001));
        vecs.push_back(mk(0,0,3,32'h0,4'hF,        1,1,4'h0, 0,0,0,0));
        vecs.push_back(mk(0,0,3,32'h0,4'hF,        1,1,4'h0, 0,0,0,0));
        vecs.push_back(mk(0,1,3,32'h77,4'hF,       1,1,4'h0, 0,0,0,0));
        vecs.push_back(mk(0,0,3,32'h0,4'hF,        1,1,4'h8, 0,0,0,32'h77));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            bus.in_valid   = vecs[i].vld;
            bus.control    = vecs[i].ctl;
            bus.input_data = vecs[i].din;
            bus.out_ready  = vecs[i].ordy;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].e_rdy});
                check($sformatf("v%0d_out_valid", i), {28'd0, bus.out_valid}, {28'd0, vecs[i].e_ov});
                check($sformatf("v%0d_output_A", i), bus.output_A, vecs[i].ea);
                check($sformatf("v%0d_output_B", i), bus.output_B, vecs[i].eb);
                check($sformatf("v%0d_output_C", i), bus.output_C, vecs[i].ec);
                check($sformatf("v%0d_output_D", i), bus.output_D, vecs[i].ed);
            end
        end

        // back-to-back stream into A with consumer always ready
        prev = 32'h0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.control    = 2'd0;
            bus.input_data = 32'hC0DE0000 + 32'(k);
            bus.out_ready  = 4'hF;
            #1;
            check($sformatf("stream%0d_in_ready", k), {31'd0, bus.in_ready}, 32'd1);
            check($sformatf("stream%0d_valid_A", k), {31'd0, bus.out_valid[0]}, (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) check($sformatf("stream%0d_output_A", k), bus.output_A, prev);
            prev = 32'hC0DE0000 + 32'(k);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("stream_tail_valid_A", {31'd0, bus.out_valid[0]}, 32'd1);
        check("stream_tail_output_A", bus.output_A, 32'hC0DE0005);

        // stalled D absorbs exactly two words before in_ready drops
        accepted = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.control    = 2'd3;
            bus.input_data = 32'hE0 + 32'(n);
            bus.out_ready  = 4'h7;
            #1;
            if (!bus.in_ready) break;
            accepted++;
        end
        check("stall_accepted", 32'(accepted), 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("stall_valid_D", {31'd0, bus.out_valid[3]}, 32'd1);
        check("stall_output_D", bus.output_D, 32'hE0);
        bus.out_ready = 4'hF;
        @(negedge clk);
        #1;
        check("stall_drain1_D", bus.output_D, 32'hE1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
